// File: rtl/sap_pkg.sv
// Shared SAP definitions: ALU op codes, control-word bit positions and flag indices.
// Imported by both the control unit and the execution datapath.
package sap_pkg;

  typedef enum logic [3:0] {
    ADD_OP = 4'd0,
    SUB_OP = 4'd1,
    INC_OP = 4'd2,
    DEC_OP = 4'd3,
    AND_OP = 4'd4,
    OR_OP  = 4'd5,
    XOR_OP = 4'd6,
    NOT_OP = 4'd7
  } alu_op_e;

  localparam int CS_W               = 14;
  localparam int CS_ACC_WRITE       = 13;
  localparam int CS_ACC_LOWER_WRITE = 12;
  localparam int CS_ALU_OP_MSB      = 11;
  localparam int CS_ALU_OP_LSB      = 8;
  localparam int CS_B_WRITE         = 7;
  localparam int CS_FLAG_WRITE      = 6;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;

endpackage

// File: rtl/acc_alu_if.sv
// Control-word / bus connection between the control unit side and the ACC/ALU datapath.
// The master drives the control word and bus value; the slave returns ACC, ALU result and flags.
interface acc_alu_if #(parameter int WIDTH = 16);
  import sap_pkg::*;

  logic [CS_W-1:0]  cs;
  logic [WIDTH-1:0] bus_in;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] alu_y;
  logic [1:0]       flag;

  modport master (output cs, output bus_in, input acc_q, input alu_y, input flag);
  modport slave  (input cs, input bus_in, output acc_q, output alu_y, output flag);

endinterface

// File: rtl/acc_alu_alu_comb.sv
// Purely combinational SAP ALU. Carry/borrow comes from a WIDTH+1 bit extended result,
// so ADD/INC report carry-out and SUB/DEC report borrow in the same bit.
module alu_comb
  import sap_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             zero
);

  logic [WIDTH:0] a_ext;
  logic [WIDTH:0] b_ext;
  logic [WIDTH:0] one_ext;
  logic [WIDTH:0] res_ext;

  assign a_ext   = {1'b0, a};
  assign b_ext   = {1'b0, b};
  assign one_ext = {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    res_ext = {1'b0, a};
    case (op)
      ADD_OP:  res_ext = a_ext + b_ext;
      SUB_OP:  res_ext = a_ext - b_ext;
      INC_OP:  res_ext = a_ext + one_ext;
      DEC_OP:  res_ext = a_ext - one_ext;
      AND_OP:  res_ext = {1'b0, a & b};
      OR_OP:   res_ext = {1'b0, a | b};
      XOR_OP:  res_ext = {1'b0, a ^ b};
      NOT_OP:  res_ext = {1'b0, ~a};
      default: res_ext = {1'b0, a};
    endcase
  end

  assign y     = res_ext[WIDTH-1:0];
  assign carry = res_ext[WIDTH];
  assign zero  = (res_ext[WIDTH-1:0] == '0);

endmodule

// File: rtl/acc_alu.sv
// SAP execution datapath: accumulator, B operand and zero/carry flag registers around the ALU.
// Flags always describe the ALU result computed from the pre-edge ACC/B.
module acc_alu
  import sap_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  acc_alu_if.slave    bus
);

  logic             acc_write;
  logic             acc_lower_write;
  logic             b_write;
  logic             flag_write;
  logic [3:0]       alu_op;

  logic [WIDTH-1:0] acc_d, acc_q;
  logic [WIDTH-1:0] b_d, b_q;
  logic [1:0]       flag_d, flag_q;

  logic [WIDTH-1:0] alu_y;
  logic             alu_carry;
  logic             alu_zero;
  logic             unused_cs;

  assign acc_write       = bus.cs[CS_ACC_WRITE];
  assign acc_lower_write = bus.cs[CS_ACC_LOWER_WRITE];
  assign alu_op          = bus.cs[CS_ALU_OP_MSB:CS_ALU_OP_LSB];
  assign b_write         = bus.cs[CS_B_WRITE];
  assign flag_write      = bus.cs[CS_FLAG_WRITE];
  assign unused_cs       = ^bus.cs[CS_FLAG_WRITE-1:0];

  alu_comb #(.WIDTH(WIDTH)) u_alu (
    .a     (acc_q),
    .b     (b_q),
    .op    (alu_op),
    .y     (alu_y),
    .carry (alu_carry),
    .zero  (alu_zero)
  );

  // Full ACC write takes priority over the low-byte (LDI) write.
  always_comb begin
    acc_d = acc_q;
    if (acc_write) begin
      acc_d = bus.bus_in;
    end else if (acc_lower_write) begin
      acc_d[7:0] = bus.bus_in[7:0];
    end

    b_d = b_q;
    if (b_write) begin
      b_d = bus.bus_in;
    end

    flag_d = flag_q;
    if (flag_write) begin
      flag_d[FLAG_Z] = alu_zero;
      flag_d[FLAG_C] = alu_carry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      b_q    <= '0;
      flag_q <= 2'b00;
    end else begin
      acc_q  <= acc_d;
      b_q    <= b_d;
      flag_q <= flag_d;
    end
  end

  assign bus.acc_q = acc_q;
  assign bus.alu_y = alu_y;
  assign bus.flag  = flag_q;

endmodule

// File: tb/tb_acc_alu.sv
// Scoreboard bench for acc_alu: a driver pushes model predictions, a monitor pops and compares.
module tb_acc_alu;

  typedef struct packed {
    logic [15:0] acc;
    logic [15:0] y;
    logic [1:0]  flag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  acc_alu_if #(.WIDTH(16)) bus_if ();

  acc_alu #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state, kept as plain integers 0..65535
  int m_acc = 0;
  int m_b   = 0;
  int m_z   = 0;
  int m_c   = 0;
  bit known = 1'b0;

  function automatic void ref_alu(input int a, input int b, input int op,
                                  output int y, output int c);
    c = 0;
    case (op)
      0: begin y = (a + b) % 65536;         c = (a + b > 65535) ? 1 : 0; end
      1: begin y = (a - b + 65536) % 65536; c = (a < b) ? 1 : 0; end
      2: begin y = (a + 1) % 65536;         c = (a == 65535) ? 1 : 0; end
      3: begin y = (a + 65535) % 65536;     c = (a == 0) ? 1 : 0; end
      4: y = a & b;
      5: y = a | b;
      6: y = a ^ b;
      7: y = 65535 - a;
      default: y = a;
    endcase
  endfunction

  task automatic step(input bit r, input bit aw, input bit alw, input int op,
                      input bit bw, input bit fw, input int bv);
    int   y, c;
    exp_t e;
    logic [5:0] junk;
    @(posedge clk);
    #2;
    junk = 6'($urandom);
    rst = r;
    bus_if.cs = {aw, alw, 4'(op), bw, fw, junk};
    bus_if.bus_in = 16'(bv);
    ref_alu(m_acc, m_b, op, y, c);
    if (known) begin
      e.acc  = 16'(m_acc);
      e.y    = 16'(y);
      e.flag = {1'(m_c), 1'(m_z)};
      exp_q.push_back(e);
    end
    if (r) begin
      m_acc = 0; m_b = 0; m_z = 0; m_c = 0;
      known = 1'b1;
    end else begin
      if (fw) begin
        m_z = (y == 0) ? 1 : 0;
        m_c = c;
      end
      if (aw)       m_acc = bv;
      else if (alw) m_acc = (m_acc / 256) * 256 + (bv % 256);
      if (bw)       m_b = bv;
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, int'($urandom_range(0, 15)), 1'b0, 1'b0, int'($urandom_range(0, 65535)));
  endtask

  task automatic load_acc(input int v);
    step(1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, v);
  endtask

  task automatic load_b(input int v);
    step(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, v);
  endtask

  // ALU result looped back into ACC with flag update, as in the ALU3 state
  task automatic alu_to_acc(input int op);
    int y, c;
    ref_alu(m_acc, m_b, op, y, c);
    step(1'b0, 1'b1, 1'b0, op, 1'b0, 1'b1, y);
  endtask

  always begin
    exp_t e;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (bus_if.acc_q !== e.acc) begin
        bad++;
        $display("FAIL acc_q: got %h expected %h at %0t", bus_if.acc_q, e.acc, $time);
      end
      total++;
      if (bus_if.alu_y !== e.y) begin
        bad++;
        $display("FAIL alu_y: got %h expected %h at %0t", bus_if.alu_y, e.y, $time);
      end
      total++;
      if (bus_if.flag !== e.flag) begin
        bad++;
        $display("FAIL flag: got %b expected %b at %0t", bus_if.flag, e.flag, $time);
      end
    end
  end

  function automatic int pick_val();
    case ($urandom_range(0, 5))
      0: return 0;
      1: return 65535;
      2: return 1;
      3: return 32768;
      default: return int'($urandom_range(0, 65535));
    endcase
  endfunction

  initial begin
    int waited;
    bus_if.cs = '0;
    bus_if.bus_in = '0;

    // Initial reset, then reset clearing preloaded state
    step(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0);
    load_acc(16'hFFFF);
    load_b(16'h0001);
    alu_to_acc(0);
    load_acc(16'h1234);
    idle();
    step(1'b1, 1'b1, 1'b1, 0, 1'b1, 1'b1, 16'hBEEF);
    idle();

    // ADD carry
    load_acc(16'hFFFF);
    load_b(16'h0001);
    alu_to_acc(0);
    idle();

    // SUB borrow, then SUB to zero
    load_acc(16'h0003);
    load_b(16'h0005);
    alu_to_acc(1);
    load_acc(5);
    load_b(5);
    alu_to_acc(1);
    idle();

    // INC / DEC / NOT wrap
    load_acc(16'hFFFF);
    alu_to_acc(2);
    alu_to_acc(3);
    alu_to_acc(7);
    idle();

    // Low-byte write, then both writes together
    load_acc(16'hAB00);
    step(1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 16'h00CD);
    load_acc(16'hAB00);
    step(1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 16'h00CD);
    idle();

    // Flag-only write with AND, B write alongside flag write, idle hold
    load_acc(16'hF0F0);
    load_b(16'h0F0F);
    step(1'b0, 1'b0, 1'b0, 4, 1'b0, 1'b1, 16'h5555);
    step(1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b1, 16'hF0F0);
    idle();
    idle();
    for (int op = 8; op < 16; op++) step(1'b0, 1'b0, 1'b0, op, 1'b0, 1'b1, 0);

    // Randomized control words and bus values
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 31) == 0), 1'($urandom), 1'($urandom),
           int'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), pick_val());
    end
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 1) == 1) alu_to_acc(int'($urandom_range(0, 15)));
      else step(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, pick_val());
    end
    idle();

    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/acc_alu.md
# acc_alu

Execution datapath of the 16-bit SAP computer, sitting directly downstream of the control unit. It holds the accumulator (ACC), the B operand register and the two-bit flag register. It computes the ALU result selected by the control word's `alu_op` field and returns the registered zero/carry flags to the control unit for JMPZ/JMPC decisions. It reads the shared 16-bit bus and presents ACC and the ALU result to the bus multiplexer, which owns tri-state/select logic.

## Interface
- `WIDTH`, default 16: datapath width. Bus, ACC, B and result all use this width.
- `clk`: input, 1 bit. Clock; all state updates on the rising edge.
- `rst`: input, 1 bit. Reset, synchronous, active-high.
- `cs`: input, 14 bits. Control word from the control unit:
  - [13] acc_write
  - [12] acc_lower_write
  - [11:8] alu_op
  - [7] b_write
  - [6] flag_write
  - [5:0] ignored by this block
- `bus_in`: input, WIDTH bits. Current value of the shared bus.
- `acc_q`: output, WIDTH bits. Registered ACC, feeding the bus mux when acc_to_bus is asserted.
- `alu_y`: output, WIDTH bits. Combinational ALU result, feeding the bus mux when alu_to_bus is asserted.
- `flag`: output, 2 bits. Registered flags: [0] = Zero, [1] = Carry.

## Operation
- Reset (rst=1 at a clock edge): ACC=0, B=0, flag=2'b00; all writes that cycle are ignored.
  - Reset values are therefore `acc_q`=0, `alu_y`=ALU(0,0) for the current `alu_op`, `flag`=0.
- ACC update, in priority order:
  - acc_write: ACC ← bus_in.
  - else acc_lower_write: ACC[7:0] ← bus_in[7:0], ACC[15:8] held.
  - else hold.
- b_write: B ← bus_in; otherwise hold.
- ALU, combinational on the current registers; A = ACC, B = B; carry is computed at WIDTH+1 bits:
  - 0 ADD: y=A+B; C = bit WIDTH of the sum.
  - 1 SUB: y=A−B mod 2^WIDTH; C = borrow (1 iff A<B unsigned).
  - 2 INC: y=A+1; C=1 iff A=all-ones.
  - 3 DEC: y=A−1; C=1 iff A=0.
  - 4 AND, 5 OR, 6 XOR: y = A op B; C=0.
  - 7 NOT: y=~A; C=0.
  - 8–15 (unused): y=A; C=0.
- Z = (y == 0) for every op.
- flag_write: flag ← {C, Z} computed from the pre-edge ACC/B; otherwise hold.
- Simultaneous events:
  - acc_write + flag_write in the same cycle (the INC/DEC/NOT and ALU3 states): flags describe the result being written; both registers update on the same edge.
  - b_write + flag_write: flags use the old B.
  - acc_write + acc_lower_write: the full write wins.

## Timing
- `alu_y` is valid in the same cycle as `alu_op`, with zero latency. The bus loops through the mux back to `bus_in` combinationally, so ACC captures the result at the end of that cycle.
- `acc_q` and `flag` change one edge after the corresponding write enable.
- Flags written in the ALU3 state are stable by the next FETCH2, where the control unit samples them; no bypass is required.
- Reset asserted mid-instruction clears all state on that edge. There is no partial write.
- Single clock domain; no handshake. Enables are trusted as one-cycle pulses from the control unit.

## Structure
- Shared package `sap_pkg`, also imported by the control unit:
  - ALU op codes (ADD_OP..NOT_OP).
  - Control-word bit indices (CS_ACC_WRITE=13, CS_ACC_LOWER_WRITE=12, CS_ALU_OP_MSB=11/LSB=8, CS_B_WRITE=7, CS_FLAG_WRITE=6).
  - Flag indices (FLAG_Z=0, FLAG_C=1).
- One sub-module, `alu_comb`: purely combinational. Inputs A, B, op; outputs y, carry, zero.
- `acc_alu` holds the three registers and the write-priority logic.

## Test plan
- Reset: preload ACC=16'h1234, B=16'h0001, flag=2'b11; assert rst one cycle → acc_q=0, flag=2'b00 on the next edge.
- ADD carry: ACC=16'hFFFF, B=16'h0001, alu_op=0, acc_write+flag_write → alu_y=16'h0000 that cycle; then ACC=0, flag=2'b11.
- SUB borrow: ACC=16'h0003, B=16'h0005, SUB → ACC=16'hFFFE, flag=2'b10.
  - Then ACC=5, B=5, SUB → ACC=0, flag=2'b01.
- INC/DEC wrap:
  - INC on ACC=16'hFFFF → 0, flag=2'b11.
  - DEC on ACC=0 → 16'hFFFF, flag=2'b10.
  - NOT on ACC=16'hFFFF → 0, flag=2'b01.
- LDI partial write: ACC=16'hAB00, bus_in=16'h00CD, acc_lower_write only → ACC=16'hABCD.
  - Same cycle with acc_write also asserted → ACC=16'h00CD.
- Hold and priority:
  - flag_write with alu_op=4 (AND) on ACC=16'hF0F0, B=16'h0F0F → flag=2'b01, ACC unchanged.
  - Idle cycles (all enables 0) → ACC, B, flag unchanged.
